// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - FSM state encodings for uart_rx_ctrl (plain 3-bit constants).
//   - Default bit period for 9600 baud from a 50 MHz clock, and the data width.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state encoding and
// the even-parity helper; without it the package describes an 8N1 receiver.
package uart_pkg;

    localparam int CLK_DIV_9600_50M = 5208;
    localparam int DATA_BITS        = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver.
// Counts 0..CLK_DIV-1 while enabled and wraps; sits at 0 while disabled so
// every frame starts timing from a known point. mid_tick marks the middle of
// each bit period (count == CLK_DIV/2), once per period.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   count enable (receiver busy)
//   mid_tick out  one-cycle strobe at the bit centre
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_9600_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mid_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLK_DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_tick = en && (cnt_q == CNT_MID);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver with a valid/ready byte output.
// The rx line is synchronised, a start edge launches the bit timer, and each
// bit is sampled at its centre. Completed bytes are handed off through
// rx_data/rx_valid; a bad stop (or parity) bit pulses frame_err, and a good
// byte arriving while the previous one is still unaccepted pulses overrun.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rx          asynchronous serial input, idles high
//   rx_data     received byte, stable while rx_valid
//   rx_valid    byte available, held until rx_ready
//   rx_ready    consumer accept
//   frame_err   one-cycle pulse on a bad frame
//   overrun     one-cycle pulse when a good byte is dropped
//   busy        high whenever a frame is in progress
// Optional feature macro: UART_RX_PARITY_EN (8E1 with a PARITY state);
// undefined builds a plain 8N1 receiver.
//
// state   | meaning
// IDLE    | waiting for a 1->0 edge on the synchronised line
// START   | timing to the start-bit centre; high there means a glitch
// DATA    | sampling 8 data bits LSB first at each bit centre
// PARITY  | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP    | sampling the stop bit, then delivering or discarding the byte
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_9600_50M,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s_prev_q, rx_s_prev_d;
    logic                   rx_s, rx_fall, mid_tick, stop_bad;
    logic [2:0]             state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err_q, parity_err_d;
`endif

    // Synchroniser chain; resets to idle-high so reset never fakes a start.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
        rx_s_prev_d = rx_s;
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_fall = rx_s_prev_q && !rx_s;
    assign busy    = (state_q != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    assign stop_bad = !rx_s || parity_err_q;
`else
    assign stop_bad = !rx_s;
`endif

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (busy),
        .mid_tick (mid_tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (rx_fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid_tick) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid_tick) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid_tick) begin
                    parity_err_d = rx_s ^ even_parity(shift_q);
                    state_d      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (mid_tick) begin
                    state_d = ST_IDLE;
                    if (stop_bad) begin
                        frame_err_d = 1'b1;
                    end else if (!rx_valid_q || rx_ready) begin
                        // An accept on this same cycle frees the slot for the new byte.
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            rx_s_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            rx_s_prev_q <= rx_s_prev_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int CLK_DIV = 16;
    localparam int SYNC    = 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Line edge -> rx_valid: synchroniser, start detect, half bit, remaining
    // bit periods up to the stop centre, then one register stage.
    localparam int LAT = SYNC + 2 + CLK_DIV / 2 + (NBITS - 1) * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    uart_rx_ctrl #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the output holding register.
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    int         start_cyc = 0;

    // Event monitor, sampled on the falling edge.
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int n_vrise = 0, n_ferr_rise = 0, n_ferr_cyc = 0, n_ovr_rise = 0, n_ovr_cyc = 0;
    int n_busy_cyc = 0, n_stab_err = 0, last_vrise_cyc = 0, last_ferr_cyc = 0;

    always @(negedge clk) begin
        prev_valid <= rx_valid;
        prev_ready <= rx_ready;
        prev_data  <= rx_data;
        prev_ferr  <= frame_err;
        prev_ovr   <= overrun;
        if (rx_valid && !prev_valid) begin
            n_vrise        <= n_vrise + 1;
            last_vrise_cyc <= cyc;
        end
        if (frame_err) n_ferr_cyc <= n_ferr_cyc + 1;
        if (frame_err && !prev_ferr) begin
            n_ferr_rise   <= n_ferr_rise + 1;
            last_ferr_cyc <= cyc;
        end
        if (overrun) n_ovr_cyc <= n_ovr_cyc + 1;
        if (overrun && !prev_ovr) n_ovr_rise <= n_ovr_rise + 1;
        if (busy) n_busy_cyc <= n_busy_cyc + 1;
        if (prev_valid && rx_valid && !prev_ready && rx_data !== prev_data)
            n_stab_err <= n_stab_err + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives the first nb bit periods of a frame: start, data LSB first,
    // optional parity (pflip inverts it), stop.
    task automatic send_bits(input logic [7:0] d, input logic stop_b,
                             input logic pflip, input int nb);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]   = (^d) ^ pflip;
        bits[10]  = stop_b;
`else
        bits[9]   = stop_b;
        if (pflip) bits[9] = stop_b;
`endif
        start_cyc = cyc;
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            wait_cycles(CLK_DIV);
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pflip);
        send_bits(d, stop_b, pflip, NBITS);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_pulses got ferr=%b ovr=%b exp=0", frame_err, overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int v0, f0;
        v0 = n_vrise; f0 = n_ferr_rise;
        send_frame(8'h55, 1'b1, 1'b0);
        wait_cycles(2);
        exp_valid = 1'b1; exp_data = 8'h55;
        checks++; if (n_vrise - v0 !== 1) begin failures++; $display("FAIL basic_vrise got=%0d exp=1", n_vrise - v0); end
        checks++; if (last_vrise_cyc - start_cyc !== LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", last_vrise_cyc - start_cyc, LAT); end
        checks++; if (rx_valid !== exp_valid || rx_data !== exp_data) begin failures++; $display("FAIL basic_data got=%b/%h exp=%b/%h", rx_valid, rx_data, exp_valid, exp_data); end
        checks++; if (n_ferr_rise - f0 !== 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", n_ferr_rise - f0); end
        rx_ready = 1'b1; wait_cycles(1); rx_ready = 1'b0;
        exp_valid = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_accept got=%b exp=0", rx_valid); end
    endtask

    task automatic test_glitch();
        int v0, f0, b0;
        v0 = n_vrise; f0 = n_ferr_rise; b0 = n_busy_cyc;
        rx = 1'b0; wait_cycles(4); rx = 1'b1;
        wait_cycles(40);
        checks++; if (n_busy_cyc - b0 !== CLK_DIV / 2 + 1) begin failures++; $display("FAIL glitch_busy_cycles got=%0d exp=%0d", n_busy_cyc - b0, CLK_DIV / 2 + 1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy); end
        checks++; if (n_vrise - v0 !== 0 || n_ferr_rise - f0 !== 0) begin failures++; $display("FAIL glitch_events got vrise=%0d ferr=%0d exp=0/0", n_vrise - v0, n_ferr_rise - f0); end
    endtask

    task automatic test_frame_err();
        int v0, f0, fc0;
        v0 = n_vrise; f0 = n_ferr_rise; fc0 = n_ferr_cyc;
        send_frame(8'hA3, 1'b0, 1'b0);
        wait_cycles(CLK_DIV);
        checks++; if (n_ferr_rise - f0 !== 1 || n_ferr_cyc - fc0 !== 1) begin failures++; $display("FAIL ferr_pulse got pulses=%0d cycles=%0d exp=1/1", n_ferr_rise - f0, n_ferr_cyc - fc0); end
        checks++; if (last_ferr_cyc - start_cyc !== LAT) begin failures++; $display("FAIL ferr_latency got=%0d exp=%0d", last_ferr_cyc - start_cyc, LAT); end
        checks++; if (n_vrise - v0 !== 0 || rx_valid !== exp_valid || rx_data !== exp_data) begin failures++; $display("FAIL ferr_discard got vrise=%0d valid=%b data=%h exp=0/%b/%h", n_vrise - v0, rx_valid, rx_data, exp_valid, exp_data); end
    endtask

    task automatic test_back_to_back();
        int v0, o0, oc0;
        v0 = n_vrise; o0 = n_ovr_rise; oc0 = n_ovr_cyc;
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        wait_cycles(2);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin failures++; $display("FAIL b2b_keep got=%b/%h exp=1/12", rx_valid, rx_data); end
        checks++; if (n_ovr_rise - o0 !== 1 || n_ovr_cyc - oc0 !== 1) begin failures++; $display("FAIL b2b_overrun got pulses=%0d cycles=%0d exp=1/1", n_ovr_rise - o0, n_ovr_cyc - oc0); end
        checks++; if (n_vrise - v0 !== 1) begin failures++; $display("FAIL b2b_vrise got=%0d exp=1", n_vrise - v0); end
        rx_ready = 1'b1; wait_cycles(1); rx_ready = 1'b0;
        exp_valid = 1'b0; exp_data = 8'h12;
    endtask

    task automatic test_back_to_back_accept();
        int v0, o0;
        v0 = n_vrise; o0 = n_ovr_rise;
        send_frame(8'h12, 1'b1, 1'b0);
        fork
            send_frame(8'h34, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        wait_cycles(2);
        exp_valid = 1'b1; exp_data = 8'h34;
        checks++; if (rx_valid !== exp_valid || rx_data !== exp_data) begin failures++; $display("FAIL b2b_accept_data got=%b/%h exp=%b/%h", rx_valid, rx_data, exp_valid, exp_data); end
        checks++; if (n_ovr_rise - o0 !== 0) begin failures++; $display("FAIL b2b_accept_overrun got=%0d exp=0", n_ovr_rise - o0); end
        checks++; if (n_vrise - v0 !== 1) begin failures++; $display("FAIL b2b_accept_vrise got=%0d exp=1", n_vrise - v0); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        // A byte (0x34) is still pending here, so the reset clearing it is visible.
        send_bits(8'hC3, 1'b1, 1'b0, 5);
        wait_cycles(6);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
            begin failures++; $display("FAIL midrst_outputs got valid=%b data=%h busy=%b ferr=%b ovr=%b exp=0/00/0/0/0", rx_valid, rx_data, busy, frame_err, overrun); end
        wait_cycles(3);
        rst_n = 1'b1;
        exp_valid = 1'b0; exp_data = 8'h00;
        v0 = n_vrise;
        wait_cycles(40);
        checks++; if (busy !== 1'b0 || n_vrise - v0 !== 0) begin failures++; $display("FAIL midrst_quiet got busy=%b vrise=%0d exp=0/0", busy, n_vrise - v0); end
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_cycles(2);
        exp_valid = 1'b1; exp_data = 8'hC3;
        checks++; if (rx_valid !== exp_valid || rx_data !== exp_data || last_vrise_cyc - start_cyc !== LAT)
            begin failures++; $display("FAIL midrst_next got=%b/%h lat=%0d exp=%b/%h lat=%0d", rx_valid, rx_data, last_vrise_cyc - start_cyc, exp_valid, exp_data, LAT); end
        rx_ready = 1'b1; wait_cycles(1); rx_ready = 1'b0;
        exp_valid = 1'b0;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, f0;
        v0 = n_vrise; f0 = n_ferr_rise;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(2);
        checks++; if (n_ferr_rise - f0 !== 1 || n_vrise - v0 !== 0 || rx_valid !== 1'b0)
            begin failures++; $display("FAIL parity_bad got ferr=%0d vrise=%0d valid=%b exp=1/0/0", n_ferr_rise - f0, n_vrise - v0, rx_valid); end
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cycles(2);
        exp_valid = 1'b1; exp_data = 8'h07;
        checks++; if (rx_valid !== exp_valid || rx_data !== exp_data) begin failures++; $display("FAIL parity_good got=%b/%h exp=1/07", rx_valid, rx_data); end
        rx_ready = 1'b1; wait_cycles(1); rx_ready = 1'b0;
        exp_valid = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [7:0] d;
        logic       bad_stop, pflip, good;
        int         f0, o0, exp_f, exp_o;
        for (int i = 0; i < 14; i++) begin
            d        = 8'($urandom_range(0, 255));
            bad_stop = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
            pflip    = ($urandom_range(0, 3) == 0);
`else
            pflip    = 1'b0;
`endif
            wait_cycles($urandom_range(0, 20));
            f0 = n_ferr_rise; o0 = n_ovr_rise;
            send_frame(d, !bad_stop, pflip);
            wait_cycles(2);
            good  = !bad_stop && !pflip;
            exp_f = good ? 0 : 1;
            exp_o = 0;
            if (good) begin
                if (exp_valid) exp_o = 1;
                else begin
                    exp_valid = 1'b1;
                    exp_data  = d;
                end
            end
            checks++; if (rx_valid !== exp_valid || rx_data !== exp_data)
                begin failures++; $display("FAIL rand%0d_data sent=%h got=%b/%h exp=%b/%h", i, d, rx_valid, rx_data, exp_valid, exp_data); end
            checks++; if (n_ferr_rise - f0 !== exp_f || n_ovr_rise - o0 !== exp_o)
                begin failures++; $display("FAIL rand%0d_events got ferr=%0d ovr=%0d exp=%0d/%0d", i, n_ferr_rise - f0, n_ovr_rise - o0, exp_f, exp_o); end
            // A low stop bit leaves the line low; restore idle before the next start.
            if (bad_stop) wait_cycles(CLK_DIV);
            if ($urandom_range(0, 1) == 1) begin
                rx_ready = 1'b1; wait_cycles(1); rx_ready = 1'b0;
                exp_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_back_to_back_accept();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        wait_cycles(4);
        checks++; if (n_stab_err !== 0) begin failures++; $display("FAIL data_stability got=%0d changes exp=0", n_stab_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
